// File: rtl/sram_type_pkg.sv
// Shared SRAM macro types, controller FSM states and the read-latency helper
// used by the TCDM-to-SRAM controller.
package sram_type_pkg;

  typedef enum logic {
    TYPE2_HS,
    TYPE2_HD
  } type2_e;

  typedef enum logic {
    WMASK_ENABLE,
    WMASK_DISABLE
  } wmask_e;

  typedef enum logic [1:0] {
    IDLE,
    RMW_WAIT,
    RMW_WR
  } rmw_state_e;

  // High-density macros need one extra cycle before read data appears.
  function automatic int unsigned rd_lat(type2_e t);
    return (t == TYPE2_HD) ? 32'd2 : 32'd1;
  endfunction

endpackage

// File: rtl/tcdm_sram_rsp_pipe.sv
// Response delay line: carries "a response is due" and "it was a read" flags
// DEPTH cycles from grant to rvalid.
module tcdm_sram_rsp_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_valid_i,
  input  logic push_read_i,
  output logic valid_o,
  output logic read_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] read_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      read_q  <= '0;
    end else begin
      valid_q[0] <= push_valid_i;
      read_q[0]  <= push_read_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        read_q[i]  <= read_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign read_o  = read_q[DEPTH-1];

endmodule

// File: rtl/tcdm_sram_ctrl.sv
// TCDM slave port in front of a single-port SRAM macro, with read-modify-write
// for partial writes on macros without bit masks. Define TCDM_SRAM_CTRL_PERF_EN
// to add saturating read/write/RMW counters.
module tcdm_sram_ctrl
  import sram_type_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter type2_e      TYPE2  = TYPE2_HS,
  parameter wmask_e      WMASK  = WMASK_ENABLE
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef TCDM_SRAM_CTRL_PERF_EN
  output logic [31:0]         cnt_rd_o,
  output logic [31:0]         cnt_wr_o,
  output logic [31:0]         cnt_rmw_o,
`endif
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                sram_csn_o,
  output logic                sram_wen_o,
  output logic [DATA_W-1:0]   sram_bwen_o,
  output logic [ADDR_W-1:0]   sram_a_o,
  output logic [DATA_W-1:0]   sram_d_o,
  input  logic [DATA_W-1:0]   sram_q_i
);

  localparam int unsigned RD_LAT = rd_lat(TYPE2);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(RD_LAT + 1);

  rmw_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0] rmw_addr_q;
  logic [BE_W-1:0]   rmw_be_q;
  logic [DATA_W-1:0] rmw_wdata_q;
  logic [DATA_W-1:0] rmw_data_q;
  logic [DATA_W-1:0] be_mask, rmw_mask;

  logic gnt, mask_off, is_rmw, is_skip;
  logic pipe_valid, pipe_read;

  assign mask_off = (WMASK == WMASK_DISABLE);
  assign gnt      = req_i && (state_q == IDLE) && !rst_i;
  assign is_rmw   = gnt && we_i && mask_off && !(&be_i) && (|be_i);
  assign is_skip  = gnt && we_i && mask_off && !(|be_i);
  assign gnt_o    = gnt;

  always_comb begin
    be_mask  = '0;
    rmw_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      be_mask[8*i +: 8]  = {8{be_i[i]}};
      rmw_mask[8*i +: 8] = {8{rmw_be_q[i]}};
    end
  end

  // An RMW reads in the grant cycle, waits RD_LAT cycles for the data, then
  // writes the merged word; the write is suppressed if reset lands on it.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sram_csn_o  = 1'b1;
    sram_wen_o  = 1'b1;
    sram_a_o    = addr_i;
    sram_d_o    = wdata_i;
    sram_bwen_o = mask_off ? '0 : ~be_mask;
    case (state_q)
      IDLE: begin
        if (gnt && !is_skip) begin
          sram_csn_o = 1'b0;
          sram_wen_o = is_rmw ? 1'b1 : ~we_i;
        end
        if (is_rmw) begin
          state_d = RMW_WAIT;
          wait_d  = CNT_W'(1);
        end
      end
      RMW_WAIT: begin
        if (wait_q == CNT_W'(RD_LAT)) state_d = RMW_WR;
        else                          wait_d  = wait_q + CNT_W'(1);
      end
      RMW_WR: begin
        sram_csn_o  = rst_i;
        sram_wen_o  = rst_i;
        sram_a_o    = rmw_addr_q;
        sram_d_o    = rmw_data_q;
        sram_bwen_o = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (is_rmw) begin
      rmw_addr_q  <= addr_i;
      rmw_be_q    <= be_i;
      rmw_wdata_q <= wdata_i;
    end
    if (state_q == RMW_WAIT && wait_q == CNT_W'(RD_LAT))
      rmw_data_q <= (sram_q_i & ~rmw_mask) | (rmw_wdata_q & rmw_mask);
  end

  tcdm_sram_rsp_pipe #(
    .DEPTH (RD_LAT)
  ) u_rsp_pipe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_valid_i (gnt && !is_rmw),
    .push_read_i  (gnt && !we_i),
    .valid_o      (pipe_valid),
    .read_o       (pipe_read)
  );

  assign rvalid_o = !rst_i && (pipe_valid || state_q == RMW_WR);
  assign rdata_o  = (!rst_i && pipe_valid && pipe_read) ? sram_q_i : '0;

`ifdef TCDM_SRAM_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_rd_o  <= '0;
      cnt_wr_o  <= '0;
      cnt_rmw_o <= '0;
    end else begin
      if (gnt && !we_i && cnt_rd_o != '1) cnt_rd_o  <= cnt_rd_o + 32'd1;
      if (gnt && we_i && cnt_wr_o != '1)  cnt_wr_o  <= cnt_wr_o + 32'd1;
      if (is_rmw && cnt_rmw_o != '1)      cnt_rmw_o <= cnt_rmw_o + 32'd1;
    end
  end
`endif

endmodule
